// File: rtl/rc4_pkg.sv
// Shared RC4 types: byte type, decryptor state encoding and
// the plaintext character bounds.
package rc4_pkg;

  typedef logic [7:0] byte_t;

  localparam byte_t CHAR_SPACE = 8'h20;
  localparam byte_t CHAR_A     = 8'h61;
  localparam byte_t CHAR_Z     = 8'h7A;

  typedef enum logic [3:0] {
    IDLE,
    INC_I,
    SEND_I,
    WAIT_I,
    COMP_J,
    SEND_J,
    WAIT_J,
    SWAP_I,
    SWAP_J,
    SEND_F,
    WAIT_F,
    XOR_WR,
    NEXT,
    DONE
  } dec_state_e;

endpackage

// File: rtl/fsm_decryptor.sv
// RC4 PRGA/decrypt stage: keystream from the shuffled S RAM,
// XOR with the encrypted ROM, plaintext check for key search.
module fsm_decryptor
  import rc4_pkg::*;
#(
  parameter int MSG_LEN     = 32,
  parameter bit EARLY_ABORT = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       In_Start,
  input  logic       Finish_ack,
  input  logic [7:0] q,
  input  logic [7:0] rom_q,
  output logic [7:0] Address,
  output logic [7:0] data,
  output logic       wren,
  output logic [7:0] rom_addr,
  output logic [7:0] dec_addr,
  output logic [7:0] dec_data,
  output logic       dec_wren,
  output logic       Start_ack,
  output logic       Decrypt_Finish,
  output logic       Msg_Valid
);

  localparam byte_t K_LAST = byte_t'(MSG_LEN - 1);

  function automatic logic is_valid_char(byte_t c);
    return (c == CHAR_SPACE) || ((c >= CHAR_A) && (c <= CHAR_Z));
  endfunction

  dec_state_e state_q, state_d;
  byte_t i_q, i_d;
  byte_t j_q, j_d;
  byte_t k_q, k_d;
  byte_t si_q, si_d;
  byte_t sj_q, sj_d;
  byte_t addr_q, addr_d;
  byte_t data_q, data_d;
  byte_t rom_addr_q, rom_addr_d;
  byte_t dec_addr_q, dec_addr_d;
  byte_t dec_data_q, dec_data_d;
  logic  ack_q, ack_d;
  logic  valid_q, valid_d;
  logic  abort_q, abort_d;
  byte_t plain;

  assign plain = q ^ rom_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      i_q        <= '0;
      j_q        <= '0;
      k_q        <= '0;
      si_q       <= '0;
      sj_q       <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      rom_addr_q <= '0;
      dec_addr_q <= '0;
      dec_data_q <= '0;
      ack_q      <= 1'b0;
      valid_q    <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      j_q        <= j_d;
      k_q        <= k_d;
      si_q       <= si_d;
      sj_q       <= sj_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      rom_addr_q <= rom_addr_d;
      dec_addr_q <= dec_addr_d;
      dec_data_q <= dec_data_d;
      ack_q      <= ack_d;
      valid_q    <= valid_d;
      abort_q    <= abort_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    j_d        = j_q;
    k_d        = k_q;
    si_d       = si_q;
    sj_d       = sj_q;
    addr_d     = addr_q;
    data_d     = data_q;
    rom_addr_d = rom_addr_q;
    dec_addr_d = dec_addr_q;
    dec_data_d = dec_data_q;
    ack_d      = 1'b0;
    valid_d    = valid_q;
    abort_d    = abort_q;
    unique case (state_q)
      IDLE: begin
        if (In_Start) begin
          ack_d   = 1'b1;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          valid_d = 1'b1;
          abort_d = 1'b0;
          state_d = INC_I;
        end
      end
      INC_I: begin
        i_d     = i_q + 8'd1;
        state_d = SEND_I;
      end
      SEND_I: begin
        addr_d  = i_q;
        state_d = WAIT_I;
      end
      WAIT_I: state_d = COMP_J;
      COMP_J: begin
        si_d    = q;
        j_d     = j_q + q;
        state_d = SEND_J;
      end
      SEND_J: begin
        addr_d     = j_q;
        rom_addr_d = k_q;
        state_d    = WAIT_J;
      end
      WAIT_J: state_d = SWAP_I;
      // Write strobes trail these states by one cycle so they
      // line up with the registered address/data.
      SWAP_I: begin
        sj_d    = q;
        addr_d  = i_q;
        data_d  = q;
        state_d = SWAP_J;
      end
      SWAP_J: begin
        addr_d  = j_q;
        data_d  = si_q;
        state_d = SEND_F;
      end
      SEND_F: begin
        addr_d  = si_q + sj_q;
        state_d = WAIT_F;
      end
      WAIT_F: state_d = XOR_WR;
      XOR_WR: begin
        dec_addr_d = k_q;
        dec_data_d = plain;
        if (!is_valid_char(plain)) begin
          valid_d = 1'b0;
          abort_d = EARLY_ABORT;
        end
        state_d = NEXT;
      end
      NEXT: begin
        if ((k_q == K_LAST) || abort_q) begin
          state_d = DONE;
        end else begin
          k_d     = k_q + 8'd1;
          state_d = INC_I;
        end
      end
      DONE: begin
        if (Finish_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign Address        = addr_q;
  assign data           = data_q;
  assign wren           = (state_q == SWAP_J) || (state_q == SEND_F);
  assign rom_addr       = rom_addr_q;
  assign dec_addr       = dec_addr_q;
  assign dec_data       = dec_data_q;
  assign dec_wren       = (state_q == NEXT);
  assign Start_ack      = ack_q;
  assign Decrypt_Finish = (state_q == DONE);
  assign Msg_Valid      = valid_q;

endmodule
